// File: rtl/fft_input_framer.sv
// fft_input_framer: collects a serial sample stream into ping-pong frame
// banks and presents each complete frame in parallel to the FFT's
// bit-reversal stage. Frames whose in_last marker disagrees with the
// sample count raise a one-cycle len_err pulse.
module fft_input_framer #(
  parameter int SAMPLES = 8,
  parameter int WIDTH   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] frame_data [SAMPLES-1:0],
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             len_err
);

  localparam int                IDX_W    = $clog2(SAMPLES);
  localparam int                DEPTH    = 2 * SAMPLES;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SAMPLES - 1);

  // Control state: per-bank full flags, write pointer, bank selectors.
  logic [1:0]       full_reg, full_next;
  logic [IDX_W-1:0] wr_idx_reg, wr_idx_next;
  logic             wr_bank_reg, wr_bank_next;
  logic             rd_bank_reg, rd_bank_next;
  logic             len_err_reg, len_err_next;

  logic accept;
  logic consume;
  logic at_end;

  // Handshake outputs come straight from registers, so no combinational
  // path exists from in_valid or frame_ready to in_ready/frame_valid.
  assign in_ready    = !full_reg[wr_bank_reg];
  assign frame_valid = full_reg[rd_bank_reg];
  assign len_err     = len_err_reg;

  assign accept  = in_valid && in_ready;
  assign consume = frame_valid && frame_ready;
  assign at_end  = (wr_idx_reg == LAST_IDX);

  // Next-state logic for the write side (fill / discard) and read side
  // (release). A completing write bank is never the full read bank, so
  // both updates to full_next can apply in the same cycle.
  always_comb begin
    full_next    = full_reg;
    wr_idx_next  = wr_idx_reg;
    wr_bank_next = wr_bank_reg;
    rd_bank_next = rd_bank_reg;
    len_err_next = 1'b0;

    if (accept) begin
      // Marker mismatch in either direction: early in_last or missing in_last.
      len_err_next = (in_last != at_end);
      if (at_end) begin
        // The frame completes on count alone, whatever in_last says.
        full_next[wr_bank_reg] = 1'b1;
        wr_bank_next           = ~wr_bank_reg;
        wr_idx_next            = '0;
      end else if (in_last) begin
        // Short frame: drop what was collected and restart the same bank.
        wr_idx_next = '0;
      end else begin
        wr_idx_next = wr_idx_reg + 1'b1;
      end
    end

    if (consume) begin
      full_next[rd_bank_reg] = 1'b0;
      rd_bank_next           = ~rd_bank_reg;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg    <= 2'b00;
      wr_idx_reg  <= '0;
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      len_err_reg <= 1'b0;
    end else begin
      full_reg    <= full_next;
      wr_idx_reg  <= wr_idx_next;
      wr_bank_reg <= wr_bank_next;
      rd_bank_reg <= rd_bank_next;
      len_err_reg <= len_err_next;
    end
  end

  // Sample storage: cells 0..SAMPLES-1 form bank 0, the rest bank 1.
  // Each cell is its own register with a decoded write enable, so reset
  // can clear the whole frame store at once.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gen_cell
      localparam logic             CELL_BANK = (gi >= SAMPLES);
      localparam logic [IDX_W-1:0] CELL_IDX  = IDX_W'(gi % SAMPLES);

      logic             we;
      logic [WIDTH-1:0] cell_reg;

      assign we = accept && (wr_bank_reg == CELL_BANK) && (wr_idx_reg == CELL_IDX);

      // Capture the accepted sample into its addressed cell.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cell_reg <= '0;
        end else if (we) begin
          cell_reg <= in_data;
        end
      end
    end

    // Present the read bank; contents only change on a write to that bank,
    // which cannot happen while it is full, so a held frame stays stable.
    for (gi = 0; gi < SAMPLES; gi++) begin : gen_out
      assign frame_data[gi] = rd_bank_reg ? gen_cell[SAMPLES + gi].cell_reg
                                          : gen_cell[gi].cell_reg;
    end
  endgenerate

endmodule

// File: tb/tb_fft_input_framer.sv
// tb_fft_input_framer: directed checks of the framer with hand-built
// expected frames; inputs change 1 time unit after the rising edge and
// outputs are sampled there too.
module tb_fft_input_framer;

  localparam int S = 8;
  localparam int W = 3;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic [W-1:0]   frame_data [S-1:0];
  logic           frame_valid;
  logic           frame_ready;
  logic           len_err;

  logic [S*W-1:0] frame_flat;
  logic [S*W-1:0] exp_a;
  logic [S*W-1:0] exp_b;

  int test_cnt = 0;
  int fail_cnt = 0;
  int frames;

  fft_input_framer #(.SAMPLES(S), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .len_err    (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flatten the parallel frame for single-value comparisons.
  always_comb begin
    frame_flat = '0;
    for (int i = 0; i < S; i++) frame_flat[i*W +: W] = frame_data[i];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] d;
    rst_n       = 1'b0;
    in_data     = '0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    frame_ready = 1'b0;

    // Reset state
    #12;
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_in_ready",    32'(in_ready),    32'd1);
    check("rst_len_err",     32'(len_err),     32'd0);
    check("rst_frame_data",  32'(frame_flat),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single frame 0..7 with frame_ready held high
    frame_ready = 1'b1;
    exp_a = '0;
    for (int i = 0; i < S; i++) begin
      d = W'(i);
      exp_a[i*W +: W] = d;
      check("f1_in_ready", 32'(in_ready), 32'd1);
      send(d, (i == S - 1));
      check("f1_len_err", 32'(len_err), 32'd0);
      check("f1_valid", 32'(frame_valid), (i == S - 1) ? 32'd1 : 32'd0);
    end
    check("f1_data", 32'(frame_flat), 32'(exp_a));
    idle();
    check("f1_valid_one_cycle", 32'(frame_valid), 32'd0);

    // Back-pressure: 16 samples fill both banks
    frame_ready = 1'b0;
    exp_a = '0;
    exp_b = '0;
    for (int i = 0; i < 2 * S; i++) begin
      if (i < S) begin
        d = W'((i * 3 + 1) % 8);
        exp_a[i*W +: W] = d;
      end else begin
        d = W'(((i - S) * 5 + 2) % 8);
        exp_b[(i-S)*W +: W] = d;
      end
      check("bp_in_ready", 32'(in_ready), 32'd1);
      send(d, ((i % S) == S - 1));
    end
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    check("bp_valid", 32'(frame_valid), 32'd1);
    check("bp_held_data", 32'(frame_flat), 32'(exp_a));
    // Ignored sample while stalled: no len_err, no change
    send(W'(5), 1'b1);
    check("bp_stall_len_err", 32'(len_err), 32'd0);
    check("bp_stall_in_ready", 32'(in_ready), 32'd0);
    check("bp_stall_data", 32'(frame_flat), 32'(exp_a));
    frame_ready = 1'b1;
    idle();
    frame_ready = 1'b0;
    check("bp_second_valid", 32'(frame_valid), 32'd1);
    check("bp_second_data", 32'(frame_flat), 32'(exp_b));
    check("bp_in_ready_back", 32'(in_ready), 32'd1);
    frame_ready = 1'b1;
    idle();
    check("bp_drained", 32'(frame_valid), 32'd0);

    // Early in_last on the third sample
    send(W'(1), 1'b0);
    send(W'(2), 1'b0);
    send(W'(3), 1'b1);
    check("short_len_err", 32'(len_err), 32'd1);
    check("short_no_valid", 32'(frame_valid), 32'd0);
    idle();
    check("short_len_err_pulse", 32'(len_err), 32'd0);
    exp_a = '0;
    for (int i = 0; i < S; i++) begin
      d = W'(7 - i);
      exp_a[i*W +: W] = d;
      send(d, (i == S - 1));
    end
    check("short_next_valid", 32'(frame_valid), 32'd1);
    check("short_next_data", 32'(frame_flat), 32'(exp_a));
    check("short_next_len_err", 32'(len_err), 32'd0);
    idle();

    // Missing in_last: frame still completes, len_err pulses
    exp_a = '0;
    for (int i = 0; i < S; i++) begin
      d = W'((2 * i + 3) % 8);
      exp_a[i*W +: W] = d;
      send(d, 1'b0);
    end
    check("nolast_len_err", 32'(len_err), 32'd1);
    check("nolast_valid", 32'(frame_valid), 32'd1);
    check("nolast_data", 32'(frame_flat), 32'(exp_a));
    idle();
    check("nolast_len_err_pulse", 32'(len_err), 32'd0);

    // 40-sample continuous stream, 5 frames, no bubbles
    frames = 0;
    exp_a = '0;
    for (int i = 0; i < 5 * S; i++) begin
      d = W'((i + i / S) % 8);
      exp_a[(i%S)*W +: W] = d;
      check("str_in_ready", 32'(in_ready), 32'd1);
      send(d, ((i % S) == S - 1));
      check("str_valid", 32'(frame_valid), ((i % S) == S - 1) ? 32'd1 : 32'd0);
      if (frame_valid) begin
        frames++;
        check("str_data", 32'(frame_flat), 32'(exp_a));
      end
    end
    check("str_frames", 32'(frames), 32'd5);
    idle();

    // Reset with one full bank and a partial second bank
    frame_ready = 1'b0;
    for (int i = 0; i < S + 5; i++) send(W'(i % 8 + 1), ((i % S) == S - 1));
    check("pre_rst_valid", 32'(frame_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(frame_valid), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    check("async_rst_data", 32'(frame_flat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b1;
    exp_a = '0;
    for (int i = 0; i < S; i++) begin
      d = W'((6 * i + 5) % 8);
      exp_a[i*W +: W] = d;
      send(d, (i == S - 1));
    end
    check("post_rst_valid", 32'(frame_valid), 32'd1);
    check("post_rst_data", 32'(frame_flat), 32'(exp_a));
    idle();

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/fft_input_framer.md
FFT_INPUT_FRAMER -- requirements
Module: fft_input_framer

Interface
REQ-001 SHALL have parameter SAMPLES, default 8, meaning samples per FFT frame; power of two, >= 2.
REQ-002 SHALL have parameter WIDTH, default 3, meaning bits per sample.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  WIDTH  meaning serial sample.
REQ-006 SHALL have port in_valid  input  1  meaning in_data/in_last valid this cycle.
REQ-007 SHALL have port in_last  input  1  meaning sample is last of its frame.
REQ-008 SHALL have port in_ready  output  1  meaning block accepts a sample this cycle.
REQ-009 SHALL have port frame_data  output  [WIDTH-1:0] x [SAMPLES-1:0] unpacked array  meaning parallel frame, element i = i-th accepted sample; feeds the bit-reversal scramble stage.
REQ-010 SHALL have port frame_valid  output  1  meaning frame_data holds a complete frame.
REQ-011 SHALL have port frame_ready  input  1  meaning downstream consumes the frame this cycle.
REQ-012 SHALL have port len_err  output  1  meaning one-cycle pulse on in_last/position mismatch.

Function
REQ-013 SHALL hold two frame banks (0, 1), each SAMPLES x WIDTH, with per-bank full flag; write index wr_idx ($clog2(SAMPLES) bits), write bank wr_bank and read bank rd_bank.
REQ-014 SHALL drive in_ready = !full[wr_bank], combinationally from registers only (no path from in_valid or frame_ready).
REQ-015 SHALL accept a sample when in_valid && in_ready: store in_data at bank[wr_bank][wr_idx], then increment wr_idx.
REQ-016 SHALL, on an accepted sample at wr_idx == SAMPLES-1: set full[wr_bank], toggle wr_bank, reset wr_idx to 0 -- regardless of in_last.
REQ-017 SHALL, on an accepted sample with in_last=1 and wr_idx < SAMPLES-1: store nothing further, discard the partial frame (wr_idx -> 0, wr_bank and full unchanged), pulse len_err next cycle.
REQ-018 SHALL pulse len_err next cycle for an accepted sample with in_last=0 at wr_idx == SAMPLES-1; that frame still completes normally.
REQ-019 SHALL drive frame_valid = full[rd_bank] and frame_data = bank[rd_bank] (registered storage, no combinational path from in_data).
REQ-020 SHALL, on frame_valid && frame_ready: clear full[rd_bank], toggle rd_bank; frame_data contents of the old bank are not cleared.
REQ-021 SHALL hold frame_data stable while frame_valid=1 and frame_ready=0.
REQ-022 Latency: last sample accepted in cycle N -> frame_valid=1 in cycle N+1 (if that bank is rd_bank).
REQ-023 Throughput: with frame_ready held 1, in_ready SHALL stay 1 continuously (one sample/cycle sustained, no bubbles).
REQ-024 Simultaneous frame completion (write bank) and consumption (read bank) in one cycle SHALL both take effect; banks differ by construction.
REQ-025 Both banks full -> in_ready=0, no writes, wr_idx held until a frame is consumed.
REQ-026 in_valid while in_ready=0 SHALL have no effect and SHALL NOT raise len_err.

Reset
REQ-027 rst_n low SHALL immediately clear: both banks to 0, full flags, wr_idx, wr_bank, rd_bank, len_err; hence frame_valid=0, in_ready=1, frame_data all 0.
REQ-028 Reset mid-frame or with full banks SHALL discard all stored samples; first sample after deassertion goes to bank 0 index 0.

Verification
REQ-029 Stream 0..7 (in_last on 7), frame_ready=1 -> frame_valid one cycle after sample 7, frame_data[i]=i, len_err never pulses.
REQ-030 Frame_ready=0, stream 16 samples back-to-back -> in_ready=1 for all 16, then 0; frame_data = first frame held; assert frame_ready one cycle -> second frame presented next cycle, in_ready returns 1.
REQ-031 in_last on 3rd sample (wr_idx=2) -> len_err one-cycle pulse, no frame_valid; next 8 samples form a complete frame starting at index 0.
REQ-032 8 samples with in_last=0 throughout -> len_err pulse after 8th, frame_valid still asserts with all 8 samples.
REQ-033 Continuous 40-sample stream with frame_ready=1 -> 5 frames, in_ready never low, each frame_valid lasts 1 cycle, contents match order.
REQ-034 rst_n low after 5 samples and with one full bank -> frame_valid=0, in_ready=1, frame_data=0 immediately; subsequent 8 samples yield correct frame.
